// File: rtl/add_num_pkg.sv
// Shared types and defaults for the add-two-numbers CCI-P sequencer.
package add_num_pkg;

    localparam int DEF_OPND_W  = 8;
    localparam int DEF_OPA_LSB = 8;
    localparam int DEF_OPB_LSB = 16;

    typedef logic [DEF_OPND_W-1:0] t_operand;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        ADD,
        WR_REQ,
        WR_WAIT,
        DONE
    } t_seq_state;

endpackage

// File: rtl/add_num_ccip_sequencer.sv
// Sequences one CCI-P transaction: c0 read of the operand line, add A+B, c1 write of the sum,
// wait for the write ack. One transaction in flight; per-wait-state timeout aborts to IDLE.
module add_num_ccip_sequencer
    import add_num_pkg::*;
#(
    parameter int ADDR_W      = 42,
    parameter int DATA_W      = 512,
    parameter int MDATA_W     = 16,
    parameter int OPND_W      = DEF_OPND_W,
    parameter int OPA_LSB     = DEF_OPA_LSB,
    parameter int OPB_LSB     = DEF_OPB_LSB,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  src_addr,
    input  logic [ADDR_W-1:0]  dst_addr,
    input  logic               c0_almfull,
    output logic               rd_req_valid,
    output logic [ADDR_W-1:0]  rd_req_addr,
    output logic [MDATA_W-1:0] rd_req_mdata,
    input  logic               rd_rsp_valid,
    input  logic [MDATA_W-1:0] rd_rsp_mdata,
    input  logic [DATA_W-1:0]  rd_rsp_data,
    input  logic               c1_almfull,
    output logic               wr_req_valid,
    output logic [ADDR_W-1:0]  wr_req_addr,
    output logic [MDATA_W-1:0] wr_req_mdata,
    output logic [DATA_W-1:0]  wr_req_data,
    input  logic               wr_rsp_valid,
    input  logic [MDATA_W-1:0] wr_rsp_mdata,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [OPND_W:0]    result,
    output logic [31:0]        txn_count
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    t_seq_state         state_q, state_d;
    logic [ADDR_W-1:0]  src_q, src_d, dst_q, dst_d;
    logic [OPND_W-1:0]  opa_q, opa_d, opb_q, opb_d;
    logic [MDATA_W-1:0] tag_q, tag_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               timeout_hit;

    logic               rd_req_valid_q, rd_req_valid_d;
    logic [ADDR_W-1:0]  rd_req_addr_q, rd_req_addr_d;
    logic [MDATA_W-1:0] rd_req_mdata_q, rd_req_mdata_d;
    logic               wr_req_valid_q, wr_req_valid_d;
    logic [ADDR_W-1:0]  wr_req_addr_q, wr_req_addr_d;
    logic [MDATA_W-1:0] wr_req_mdata_q, wr_req_mdata_d;
    logic [DATA_W-1:0]  wr_req_data_q, wr_req_data_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [OPND_W:0]    result_q, result_d;
    logic [31:0]        txn_count_q, txn_count_d;

    // Only the operand fields of the response line are consumed.
    logic unused_rsp_bits;
    assign unused_rsp_bits = ^rd_rsp_data;

    // Wait-state cycle counter; zero on every cycle outside a wait state, so it is clear on entry.
    always_comb begin
        to_cnt_d = '0;
        if (state_q == RD_WAIT || state_q == WR_WAIT) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d        = state_q;
        src_d          = src_q;
        dst_d          = dst_q;
        opa_d          = opa_q;
        opb_d          = opb_q;
        tag_d          = tag_q;
        rd_req_valid_d = 1'b0;
        rd_req_addr_d  = rd_req_addr_q;
        rd_req_mdata_d = rd_req_mdata_q;
        wr_req_valid_d = 1'b0;
        wr_req_addr_d  = wr_req_addr_q;
        wr_req_mdata_d = wr_req_mdata_q;
        wr_req_data_d  = wr_req_data_q;
        done_d         = 1'b0;
        error_d        = error_q;
        result_d       = result_q;
        txn_count_d    = txn_count_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    error_d = 1'b0;
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                if (!c0_almfull) begin
                    rd_req_valid_d = 1'b1;
                    rd_req_addr_d  = src_q;
                    rd_req_mdata_d = tag_q;
                    state_d        = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rd_rsp_valid && rd_rsp_mdata == tag_q) begin
                    opa_d   = rd_rsp_data[OPA_LSB +: OPND_W];
                    opb_d   = rd_rsp_data[OPB_LSB +: OPND_W];
                    state_d = ADD;
                end else if (timeout_hit) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end
            ADD: begin
                result_d = {1'b0, opa_q} + {1'b0, opb_q};
                state_d  = WR_REQ;
            end
            WR_REQ: begin
                // The write carries the next tag so its ack is distinguishable from the read's.
                if (!c1_almfull) begin
                    wr_req_valid_d = 1'b1;
                    wr_req_addr_d  = dst_q;
                    wr_req_mdata_d = tag_q + MDATA_W'(1);
                    wr_req_data_d  = {{(DATA_W - OPND_W - 1){1'b0}}, result_q};
                    tag_d          = tag_q + MDATA_W'(1);
                    state_d        = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (wr_rsp_valid && wr_rsp_mdata == tag_q) begin
                    state_d = DONE;
                end else if (timeout_hit) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end
            DONE: begin
                done_d      = 1'b1;
                txn_count_d = txn_count_q + 32'd1;
                tag_d       = tag_q + MDATA_W'(1);
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            src_q          <= '0;
            dst_q          <= '0;
            opa_q          <= '0;
            opb_q          <= '0;
            tag_q          <= '0;
            rd_req_valid_q <= 1'b0;
            rd_req_addr_q  <= '0;
            rd_req_mdata_q <= '0;
            wr_req_valid_q <= 1'b0;
            wr_req_addr_q  <= '0;
            wr_req_mdata_q <= '0;
            wr_req_data_q  <= '0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            result_q       <= '0;
            txn_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            src_q          <= src_d;
            dst_q          <= dst_d;
            opa_q          <= opa_d;
            opb_q          <= opb_d;
            tag_q          <= tag_d;
            rd_req_valid_q <= rd_req_valid_d;
            rd_req_addr_q  <= rd_req_addr_d;
            rd_req_mdata_q <= rd_req_mdata_d;
            wr_req_valid_q <= wr_req_valid_d;
            wr_req_addr_q  <= wr_req_addr_d;
            wr_req_mdata_q <= wr_req_mdata_d;
            wr_req_data_q  <= wr_req_data_d;
            done_q         <= done_d;
            error_q        <= error_d;
            result_q       <= result_d;
            txn_count_q    <= txn_count_d;
        end
    end

    assign rd_req_valid = rd_req_valid_q;
    assign rd_req_addr  = rd_req_addr_q;
    assign rd_req_mdata = rd_req_mdata_q;
    assign wr_req_valid = wr_req_valid_q;
    assign wr_req_addr  = wr_req_addr_q;
    assign wr_req_mdata = wr_req_mdata_q;
    assign wr_req_data  = wr_req_data_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign error        = error_q;
    assign result       = result_q;
    assign txn_count    = txn_count_q;

endmodule

// File: tb/tb_add_num_ccip_sequencer.sv
// Directed bench for add_num_ccip_sequencer: acts as a zero-latency CCI-P memory and checks
// addresses, tags, sums, latency, almfull hold-off, tag filtering, timeout and reset abort.
module tb_add_num_ccip_sequencer;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [41:0]  src_addr, dst_addr;
    logic         c0_almfull;
    logic         rd_req_valid;
    logic [41:0]  rd_req_addr;
    logic [15:0]  rd_req_mdata;
    logic         rd_rsp_valid;
    logic [15:0]  rd_rsp_mdata;
    logic [511:0] rd_rsp_data;
    logic         c1_almfull;
    logic         wr_req_valid;
    logic [41:0]  wr_req_addr;
    logic [15:0]  wr_req_mdata;
    logic [511:0] wr_req_data;
    logic         wr_rsp_valid;
    logic [15:0]  wr_rsp_mdata;
    logic         busy, done, error;
    logic [8:0]   result;
    logic [31:0]  txn_count;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_tag;
    int          exp_cnt;

    always #5 clk = ~clk;

    add_num_ccip_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .c0_almfull   (c0_almfull),
        .rd_req_valid (rd_req_valid),
        .rd_req_addr  (rd_req_addr),
        .rd_req_mdata (rd_req_mdata),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_mdata (rd_rsp_mdata),
        .rd_rsp_data  (rd_rsp_data),
        .c1_almfull   (c1_almfull),
        .wr_req_valid (wr_req_valid),
        .wr_req_addr  (wr_req_addr),
        .wr_req_mdata (wr_req_mdata),
        .wr_req_data  (wr_req_data),
        .wr_rsp_valid (wr_rsp_valid),
        .wr_rsp_mdata (wr_rsp_mdata),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .result       (result),
        .txn_count    (txn_count)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One full transaction; exp_lat is the cycle offset from the start cycle to the done pulse.
    task automatic do_txn(input logic [41:0] src, input logic [41:0] dst,
                          input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp_sum,
                          input bit bad_tag, input int hold, input bit dbl_start, input int exp_lat);
        logic [511:0] line, bad_line, exp_wr;
        logic [15:0]  rtag;
        int           rd_seen, wr_k, done_k, wr_viol, extra;
        bit           rd_pending, alm_edge;
        line = '0;     line[15:8] = a;        line[23:16] = b;
        bad_line = '0; bad_line[15:8] = 8'h55; bad_line[23:16] = 8'h66;
        exp_wr = '0;   exp_wr[8:0] = exp_sum;
        rtag = '0; rd_seen = 0; wr_k = -1; done_k = -1; wr_viol = 0; rd_pending = 0;
        @(negedge clk);
        start = 1'b1; src_addr = src; dst_addr = dst; c1_almfull = (hold > 0);
        for (int k = 1; k <= 200 && done_k < 0; k++) begin
            @(negedge clk);
            alm_edge = c1_almfull;
            start = dbl_start && (k == 3);
            src_addr = ~src; dst_addr = ~dst;
            rd_rsp_valid = 1'b0; wr_rsp_valid = 1'b0;
            if (k == 1) begin
                check("busy_after_start", busy, 1);
                check("error_clear_on_start", error, 0);
            end
            if (hold > 0 && k == 4 + hold) c1_almfull = 1'b0;
            if (rd_pending) begin
                rd_rsp_valid = 1'b1; rd_rsp_mdata = rtag; rd_rsp_data = line; rd_pending = 0;
            end
            if (rd_req_valid) begin
                rd_seen++;
                rtag = rd_req_mdata;
                check("rd_addr", rd_req_addr, src);
                check("rd_tag", rd_req_mdata, exp_tag);
                rd_rsp_valid = 1'b1;
                if (bad_tag) begin
                    rd_rsp_mdata = rtag ^ 16'h8000; rd_rsp_data = bad_line; rd_pending = 1;
                end else begin
                    rd_rsp_mdata = rtag; rd_rsp_data = line;
                end
            end
            if (wr_req_valid) begin
                wr_k = k;
                if (alm_edge) wr_viol++;
                check("wr_addr", wr_req_addr, dst);
                check("wr_data", wr_req_data, exp_wr);
                check("wr_tag", wr_req_mdata, exp_tag + 16'd1);
                wr_rsp_valid = 1'b1; wr_rsp_mdata = wr_req_mdata;
            end
            if (done) done_k = k;
        end
        start = 1'b0; c1_almfull = 1'b0;
        exp_cnt++;
        exp_tag = exp_tag + 16'd2;
        check("done_latency", done_k, exp_lat);
        check("wr_issue_cycle", wr_k, exp_lat - 2);
        check("rd_req_count", rd_seen, 1);
        check("wr_during_almfull", wr_viol, 0);
        check("result", result, exp_sum);
        check("txn_count", txn_count, exp_cnt);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (rd_req_valid || wr_req_valid || busy) extra++;
        end
        check("idle_after_txn", extra, 0);
    endtask

    task automatic do_timeout();
        int n;
        bit got_rd, saw_done;
        @(negedge clk);
        start = 1'b1; src_addr = 42'h777; dst_addr = 42'h888;
        @(negedge clk);
        start = 1'b0;
        got_rd = 0;
        for (int k = 0; k < 20 && !got_rd; k++) begin
            @(negedge clk);
            if (rd_req_valid) got_rd = 1;
        end
        check("timeout_rd_issued", got_rd, 1);
        check("timeout_rd_tag", rd_req_mdata, exp_tag);
        n = 0; saw_done = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
            if (done) saw_done = 1;
        end
        check("timeout_cycles", n, 4096);
        check("timeout_error", error, 1);
        check("timeout_busy", busy, 0);
        check("timeout_no_done", saw_done, 0);
        check("timeout_count", txn_count, exp_cnt);
        repeat (3) @(negedge clk);
        check("error_sticky", error, 1);
    endtask

    task automatic do_reset_abort();
        logic [15:0] rtag;
        bit got_rd;
        int seen;
        @(negedge clk);
        start = 1'b1; src_addr = 42'h4C0; dst_addr = 42'h4D0;
        @(negedge clk);
        start = 1'b0;
        got_rd = 0; rtag = '0;
        for (int k = 0; k < 20 && !got_rd; k++) begin
            @(negedge clk);
            if (rd_req_valid) begin got_rd = 1; rtag = rd_req_mdata; end
        end
        check("abort_rd_issued", got_rd, 1);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        rd_rsp_valid = 1'b1; rd_rsp_mdata = rtag;
        rd_rsp_data = '0; rd_rsp_data[15:8] = 8'h01; rd_rsp_data[23:16] = 8'h02;
        @(negedge clk);
        rd_rsp_valid = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_result", result, 0);
        check("abort_count", txn_count, 0);
        check("abort_rd_addr", rd_req_addr, 0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (rd_req_valid || wr_req_valid || done || busy) seen++;
        end
        check("abort_stays_idle", seen, 0);
        exp_cnt = 0;
        exp_tag = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0;
        c0_almfull = 1'b0; c1_almfull = 1'b0;
        rd_rsp_valid = 1'b0; rd_rsp_mdata = '0; rd_rsp_data = '0;
        wr_rsp_valid = 1'b0; wr_rsp_mdata = '0;
        exp_tag = '0; exp_cnt = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_outputs",
              {rd_req_valid, wr_req_valid, busy, done, error, result, txn_count, rd_req_mdata},
              '0);
        check("reset_wr_data", wr_req_data, '0);

        //     src      dst      A      B      sum     bad hold dbl lat
        do_txn(42'h100, 42'h200, 8'h03, 8'h04, 9'h007, 0,  0,   0,  7);
        do_txn(42'h140, 42'h240, 8'hFF, 8'hFF, 9'h1FE, 0,  0,   0,  7);
        do_txn(42'h180, 42'h280, 8'h12, 8'h34, 9'h046, 0,  10,  0,  17);
        do_txn(42'h1C0, 42'h2C0, 8'h09, 8'h80, 9'h089, 1,  0,   0,  8);
        do_timeout();
        do_txn(42'h300, 42'h310, 8'h7F, 8'h01, 9'h080, 0,  0,   1,  7);
        do_reset_abort();
        do_txn(42'h500, 42'h510, 8'h20, 8'h22, 9'h042, 0,  0,   0,  7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
